// File: rtl/bike_light_pkg.sv
// Shared types and widths for the bike-light front panel: mode encoding,
// speed-level width and the mode-advance rule.
package bike_light_pkg;

  localparam int SPEED_W = 3;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    ON     = 2'd1,
    FLASH1 = 2'd2,
    FLASH2 = 2'd3
  } mode_t;

  function automatic mode_t next_mode(input mode_t cur);
    case (cur)
      OFF:     return ON;
      ON:      return FLASH1;
      FLASH1:  return FLASH2;
      FLASH2:  return OFF;
      default: return OFF;
    endcase
  endfunction

endpackage

// File: rtl/blinker_mode_controller_speed_level_ctr.sv
// Saturating speed-level tracker for one blinker; emits a one-cycle shift
// pulse only when the level actually moves, so the blinker never leaves range.
module speed_level_ctr
  import bike_light_pkg::*;
#(
  parameter int SPEED_MAX   = 7,
  parameter int SPEED_RESET = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  output logic [SPEED_W-1:0] level,
  output logic               shl_pulse,
  output logic               shr_pulse
);

  localparam logic [SPEED_W-1:0] LVL_MAX = SPEED_W'(SPEED_MAX);
  localparam logic [SPEED_W-1:0] LVL_RST = SPEED_W'(SPEED_RESET);
  localparam logic [SPEED_W-1:0] LVL_ONE = SPEED_W'(1);
  localparam logic [SPEED_W-1:0] LVL_MIN = SPEED_W'(0);

  logic [SPEED_W-1:0] level_r;
  logic [SPEED_W-1:0] level_nxt_s;
  logic               shl_r;
  logic               shr_r;
  logic               shl_nxt_s;
  logic               shr_nxt_s;

  // Next level and pulse request; conflicting inc+dec moves nothing.
  always_comb begin
    level_nxt_s = level_r;
    shl_nxt_s   = 1'b0;
    shr_nxt_s   = 1'b0;
    if (inc && !dec && (level_r < LVL_MAX)) begin
      level_nxt_s = level_r + LVL_ONE;
      shl_nxt_s   = 1'b1;
    end else if (dec && !inc && (level_r > LVL_MIN)) begin
      level_nxt_s = level_r - LVL_ONE;
      shr_nxt_s   = 1'b1;
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Level and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r <= LVL_RST;
      shl_r   <= 1'b0;
      shr_r   <= 1'b0;
    end else begin
      level_r <= level_nxt_s;
      shl_r   <= shl_nxt_s;
      shr_r   <= shr_nxt_s;
    end
  end

  assign level     = level_r;
  assign shl_pulse = shl_r;
  assign shr_pulse = shr_r;

endmodule

// File: rtl/blinker_mode_controller.sv
// Bike-light front-panel sequencer: mode FSM, idle auto-off counter, per-blinker
// speed tracking and the LED source mux.
module blinker_mode_controller
  import bike_light_pkg::*;
#(
  parameter int SPEED_MAX   = 7,
  parameter int SPEED_RESET = 3,
  parameter int IDLE_BEATS  = 1920
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               beat,
  input  logic               btn_mode,
  input  logic               btn_faster,
  input  logic               btn_slower,
  input  logic               blink1,
  input  logic               blink2,
  output logic               shift_left1,
  output logic               shift_right1,
  output logic               shift_left2,
  output logic               shift_right2,
  output logic               light,
  output logic [1:0]         mode,
  output logic [SPEED_W-1:0] level1,
  output logic [SPEED_W-1:0] level2
);

  localparam int IDLE_W = $clog2(IDLE_BEATS + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BEATS - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_ZERO = IDLE_W'(0);

  mode_t             mode_r;
  mode_t             mode_nxt_s;
  logic [IDLE_W-1:0] idle_r;
  logic [IDLE_W-1:0] idle_nxt_s;
  logic              any_btn_s;
  logic              speed_ok_s;
  logic              inc1_s;
  logic              dec1_s;
  logic              inc2_s;
  logic              dec2_s;

  // A lone speed button is honoured; mode press or both speed buttons mask it.
  always_comb begin
    speed_ok_s = (btn_faster ^ btn_slower) && !btn_mode;
    inc1_s     = speed_ok_s && btn_faster && (mode_r == FLASH1);
    dec1_s     = speed_ok_s && btn_slower && (mode_r == FLASH1);
    inc2_s     = speed_ok_s && btn_faster && (mode_r == FLASH2);
    dec2_s     = speed_ok_s && btn_slower && (mode_r == FLASH2);
  end

  // Mode advance and idle timeout; a button in the timeout cycle takes priority.
  always_comb begin
    any_btn_s  = btn_mode | btn_faster | btn_slower;
    mode_nxt_s = mode_r;
    idle_nxt_s = idle_r;
    if (any_btn_s) begin
      idle_nxt_s = IDLE_ZERO;
      if (btn_mode) begin
        mode_nxt_s = next_mode(mode_r);
      end else begin
        mode_nxt_s = mode_r;
      end
    end else if (beat && (mode_r != OFF)) begin
      if (idle_r >= IDLE_LAST) begin
        mode_nxt_s = OFF;
        idle_nxt_s = IDLE_ZERO;
      end else begin
        idle_nxt_s = idle_r + IDLE_ONE;
      end
    end else begin
      idle_nxt_s = idle_r;
    end
  end

  // Mode and idle-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r <= OFF;
      idle_r <= IDLE_ZERO;
    end else begin
      mode_r <= mode_nxt_s;
      idle_r <= idle_nxt_s;
    end
  end

  speed_level_ctr #(
    .SPEED_MAX  (SPEED_MAX),
    .SPEED_RESET(SPEED_RESET)
  ) u_speed1 (
    .clk      (clk),
    .reset    (reset),
    .inc      (inc1_s),
    .dec      (dec1_s),
    .level    (level1),
    .shl_pulse(shift_left1),
    .shr_pulse(shift_right1)
  );

  speed_level_ctr #(
    .SPEED_MAX  (SPEED_MAX),
    .SPEED_RESET(SPEED_RESET)
  ) u_speed2 (
    .clk      (clk),
    .reset    (reset),
    .inc      (inc2_s),
    .dec      (dec2_s),
    .level    (level2),
    .shl_pulse(shift_left2),
    .shr_pulse(shift_right2)
  );

  // LED source is combinational so blink edges pass through without delay.
  always_comb begin
    light = 1'b0;
    case (mode_r)
      OFF:     light = 1'b0;
      ON:      light = 1'b1;
      FLASH1:  light = blink1;
      FLASH2:  light = blink2;
      default: light = 1'b0;
    endcase
  end

  assign mode = mode_r;

endmodule
